// File: rtl/branch_ctrl_pkg.sv
// branch_ctrl_pkg: shared definitions for the ID-stage branch controller.
//   - branch code constants carried on id_branch_signal
//   - FSM state encoding of branch_ctrl
//   - small decode helpers for branch codes
package branch_ctrl_pkg;

    localparam logic [2:0] BR_BEQ  = 3'b100;
    localparam logic [2:0] BR_BNE  = 3'b101;
    localparam logic [2:0] BR_BLTZ = 3'b001;
    localparam logic [2:0] BR_BGTZ = 3'b111;
    localparam logic [2:0] BR_BLEZ = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STALL = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // True for the five codes that denote a branch; all others are non-branches.
    function automatic logic is_branch(input logic [2:0] code);
        return (code == BR_BEQ) || (code == BR_BNE) || (code == BR_BLTZ) ||
               (code == BR_BGTZ) || (code == BR_BLEZ);
    endfunction

    // Only the two-operand compares read rt.
    function automatic logic uses_rt(input logic [2:0] code);
        return (code == BR_BEQ) || (code == BR_BNE);
    endfunction

endpackage

// File: rtl/branch_cond.sv
// branch_cond: combinational branch condition evaluator.
// Ports:
//   op_a  in  32  rs operand (after forwarding selection)
//   op_b  in  32  rt operand (after forwarding selection)
//   code  in  3   branch code
//   taken out 1   condition holds (0 for non-branch codes)
module branch_cond
    import branch_ctrl_pkg::*;
(
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [2:0]  code,
    output logic        taken
);

    logic a_neg;
    logic a_zero;

    assign a_neg  = op_a[31];
    assign a_zero = (op_a == 32'd0);

    always_comb begin
        taken = 1'b0;
        case (code)
            BR_BEQ:  taken = (op_a == op_b);
            BR_BNE:  taken = (op_a != op_b);
            BR_BLTZ: taken = a_neg;
            BR_BGTZ: taken = !a_neg && !a_zero;
            BR_BLEZ: taken = a_neg || a_zero;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_ctrl.sv
// branch_ctrl: branch-resolution controller for the ID stage.
// Detects data hazards on the branch operands, stalls IF/ID for the needed
// number of cycles, selects MEM forwarding, resolves the branch and counts
// resolved / taken branches.
// Ports:
//   clk, reset (async, active low)
//   id_valid, id_branch_signal, id_rs, id_rt      ID instruction
//   rf_rs_data, rf_rt_data                        register-file read data
//   ex_reg_write, ex_mem_read, ex_rd               EX-stage producer
//   mem_reg_write, mem_mem_read, mem_rd            MEM-stage producer
//   mem_alu_result                                 MEM forwarding source
//   kill                                           synchronous flush
//   id_stall, ex_bubble                            stall controls
//   branch_taken, if_flush                         resolve pulse
//   fwd_rs_sel, fwd_rt_sel                         operand source selects
//   busy                                           FSM not in IDLE
//   branch_cnt, taken_cnt                          statistics (wrap-around)
//   state_dbg                                      current FSM state
//
// Control outputs are combinational: a hazard-free branch must resolve in the
// same cycle it appears in ID, and a hazard must stall that same cycle.
//
// Handshake note: there is no valid/ready pair here; id_valid qualifies the ID
// instruction every cycle and the instruction is assumed held in ID for as
// long as id_stall is asserted.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [2:0]       id_branch_signal,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [31:0]      rf_rs_data,
    input  logic [31:0]      rf_rt_data,
    input  logic             ex_reg_write,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             mem_reg_write,
    input  logic             mem_mem_read,
    input  logic [4:0]       mem_rd,
    input  logic [31:0]      mem_alu_result,
    input  logic             kill,
    output logic             id_stall,
    output logic             ex_bubble,
    output logic             branch_taken,
    output logic             if_flush,
    output logic             fwd_rs_sel,
    output logic             fwd_rt_sel,
    output logic             busy,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [1:0]       state_dbg
);

    state_t     state;
    logic [1:0] stall_cnt;

    // Returns {forward, need[1:0]} for one operand register.
    // The younger EX producer takes priority over MEM; r0 never matches.
    function automatic logic [2:0] classify(
        input logic [4:0] r,
        input logic       exw,
        input logic       exl,
        input logic [4:0] exd,
        input logic       mw,
        input logic       ml,
        input logic [4:0] md
    );
        logic [2:0] res;
        res = 3'b000;
        if (r != 5'd0) begin
            if (exl && exd == r)
                res = 3'b010;
            else if ((exw && exd == r) || (ml && md == r))
                res = 3'b001;
            else if (mw && !ml && md == r)
                res = 3'b100;
        end
        return res;
    endfunction

    logic [2:0]  rs_cls;
    logic [2:0]  rt_cls;
    logic [1:0]  need;
    logic        eval;
    logic        resolve;
    logic        stall_start;
    logic [31:0] rs_op;
    logic [31:0] rt_op;
    logic        cond_taken;

    always_comb begin
        rs_cls = classify(id_rs, ex_reg_write, ex_mem_read, ex_rd,
                          mem_reg_write, mem_mem_read, mem_rd);
        rt_cls = 3'b000;
        if (uses_rt(id_branch_signal))
            rt_cls = classify(id_rt, ex_reg_write, ex_mem_read, ex_rd,
                              mem_reg_write, mem_mem_read, mem_rd);
        need = (rs_cls[1:0] > rt_cls[1:0]) ? rs_cls[1:0] : rt_cls[1:0];
    end

    // Classification is only meaningful in IDLE and CHECK; STALL ignores inputs.
    assign eval = reset && id_valid && is_branch(id_branch_signal) &&
                  (state == ST_IDLE || state == ST_CHECK);
    assign resolve     = eval && (need == 2'd0) && !kill;
    assign stall_start = eval && (need != 2'd0) && !kill;

    assign fwd_rs_sel = eval && rs_cls[2];
    assign fwd_rt_sel = eval && rt_cls[2];
    assign rs_op      = fwd_rs_sel ? mem_alu_result : rf_rs_data;
    assign rt_op      = fwd_rt_sel ? mem_alu_result : rf_rt_data;

    branch_cond u_cond (
        .op_a  (rs_op),
        .op_b  (rt_op),
        .code  (id_branch_signal),
        .taken (cond_taken)
    );

    assign id_stall     = reset && !kill && (state == ST_STALL || stall_start);
    assign ex_bubble    = id_stall;
    assign branch_taken = resolve && cond_taken;
    assign if_flush     = branch_taken;
    assign busy         = reset && (state != ST_IDLE);
    assign state_dbg    = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            stall_cnt  <= 2'd0;
            branch_cnt <= '0;
            taken_cnt  <= '0;
        end else if (kill) begin
            state     <= ST_IDLE;
            stall_cnt <= 2'd0;
        end else begin
            case (state)
                ST_IDLE, ST_CHECK: begin
                    if (stall_start) begin
                        // need-1 further stall cycles remain after this one.
                        stall_cnt <= need - 2'd1;
                        state     <= (need == 2'd1) ? ST_CHECK : ST_STALL;
                    end else begin
                        if (resolve) begin
                            branch_cnt <= branch_cnt + CNT_W'(1);
                            if (cond_taken)
                                taken_cnt <= taken_cnt + CNT_W'(1);
                        end
                        state <= ST_IDLE;
                    end
                end
                ST_STALL: begin
                    // A zero count here cannot occur legally; leave rather than wedge.
                    if (stall_cnt <= 2'd1) begin
                        stall_cnt <= 2'd0;
                        state     <= ST_CHECK;
                    end else begin
                        stall_cnt <= stall_cnt - 2'd1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    stall_cnt <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
Branch-resolution controller for the ID stage of the 5-stage MIPS pipeline. It detects data hazards on branch operands and stalls ID/IF for the required number of cycles. It selects operand forwarding from MEM, evaluates the branch condition, and issues the taken/flush pulse to IF. It also keeps branch and taken-branch statistics counters.

Parameters:
CNT_W, 32, width of the statistics counters (wrap-around, no saturation)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
id_valid  in  1  ID holds a real instruction
id_branch_signal  in  3  100 beq, 101 bne, 001 bltz, 111 bgtz, 110 blez, other codes = no branch
id_rs, id_rt  in  5  source register numbers of the ID instruction
rf_rs_data, rf_rt_data  in  32  register-file read data (WB write-before-read guaranteed)
ex_reg_write, ex_mem_read  in  1  EX-stage write-enable / load flag
ex_rd  in  5  EX-stage destination
mem_reg_write, mem_mem_read  in  1  MEM-stage write-enable / load flag
mem_rd  in  5  MEM-stage destination
mem_alu_result  in  32  MEM-stage ALU result (forwarding source)
kill  in  1  synchronous pipeline flush (exception); aborts any branch in progress
id_stall  out  1  hold PC and IF/ID
ex_bubble  out  1  insert NOP into ID/EX
branch_taken  out  1  branch resolved taken this cycle (pc_src select)
if_flush  out  1  flush IF/ID (equal to branch_taken)
fwd_rs_sel, fwd_rt_sel  out  1  0 = register file, 1 = mem_alu_result
busy  out  1  FSM not in IDLE
branch_cnt, taken_cnt  out  CNT_W  resolved branches / taken branches

Behaviour:
- Reset (reset=0, async): state IDLE, stall counter 0, branch_cnt=taken_cnt=0, and all outputs 0.
- Operand use: rs is used by every branch code. rt is used only by beq/bne. Register 0 never matches.
- Hazard classification, evaluated combinationally in IDLE and CHECK for a used operand r:
  - ex_mem_read and ex_rd==r gives need=2.
  - Otherwise, ex_reg_write and ex_rd==r, or mem_mem_read and mem_rd==r, gives need=1.
  - Otherwise, mem_reg_write and !mem_mem_read and mem_rd==r gives forward (fwd_*_sel=1, need=0).
  - Otherwise the operand is taken from the register file.
  - Overall need is the max over used operands.
- States IDLE, STALL, CHECK:
  - IDLE: if id_valid and the code is a branch:
    - need=0: resolve in the same cycle.
    - need>0: assert id_stall=ex_bubble=1 and load the counter with need-1. Go to CHECK if need-1 is 0, else go to STALL.
  - STALL: assert id_stall=ex_bubble=1 regardless of inputs. Decrement the counter. Go to CHECK when it reaches 0.
  - CHECK: re-classify. need=0 resolves and returns to IDLE. need>0 re-stalls as in IDLE (defensive path; not reached in legal operation).
- Resolve cycle, combinational, no stall:
  - Evaluate the condition on the selected operands: beq equal; bne not equal; bltz rs signed <0; bgtz rs signed >0; blez rs signed <=0.
  - branch_taken=if_flush=condition.
  - branch_cnt+1, and taken_cnt+1 if taken, at the clock edge.
- Latency: 0 extra cycles with no hazard or MEM forwarding. 1 stall cycle for an EX ALU producer or a MEM load. 2 stall cycles for an EX load.
- kill=1: next state IDLE, counter cleared, and branch_taken/if_flush/id_stall/ex_bubble forced 0 that cycle. Counters do not increment. kill has priority over all other events.
- Non-branch codes, or id_valid=0, in IDLE: all control outputs 0, fwd_*_sel 0.
- Counters wrap modulo 2^CNT_W.

Decomposition:
- Shared package holds the branch code constants (BR_BEQ=3'b100, BR_BNE=3'b101, BR_BLTZ=3'b001, BR_BGTZ=3'b111, BR_BLEZ=3'b110) and the FSM state encoding.
- One sub-module, branch_cond: a combinational condition evaluator taking two 32-bit operands and the code, producing taken.
- Hazard classification, FSM and counters stay in branch_ctrl.

Test Plan:
- No hazard: beq, rs=rt=5, rf data both 0x1234 -> branch_taken=if_flush=1 same cycle, id_stall=0, branch_cnt=1, taken_cnt=1.
- MEM forward: bne rs=3, mem_reg_write=1, mem_rd=3, mem_alu_result=7, rf_rt=7 -> fwd_rs_sel=1, not taken, no stall.
- EX load: beq rs=4, ex_mem_read=1, ex_rd=4 -> id_stall=ex_bubble=1 for exactly 2 cycles, resolve in cycle 3.
- EX ALU producer: bgtz rs=2, ex_reg_write=1, ex_rd=2 -> 1 stall, then mem_alu_result=0x80000000 gives not taken; a value of 1 gives taken.
- Boundary: blez with rs=0 -> taken. bltz with rt hazard only (ex_rd=rt) -> no stall. ex_rd=0 -> never a hazard.
- kill during STALL cycle 1 of an EX load -> IDLE next cycle, no taken, counters unchanged. Async reset asserted mid-STALL -> all outputs 0 immediately.
